// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// Optional feature macro used by fetch_buf: FETCH_BUF_BYPASS_EN.
package fetch_pkg;

   localparam int          FETCH_DEPTH_DEF = 4;
   localparam logic [31:0] PC_STEP         = 32'd4;

   // One buffered fetch: the address and the word read from it
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Sequential fetch address, wrapping modulo 2^32
   function automatic logic [31:0] nextPc(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular queue of fetched instructions with a flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         enq,
   input  fetch_entry_t                 enqData,
   input  logic                         deq,
   output fetch_entry_t                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);

   localparam int             PW         = $clog2(DEPTH);
   localparam int             CW         = $clog2(DEPTH+1);
   localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [PW-1:0]  wrPtr;
   logic [PW-1:0]  rdPtr;

   // Pointer and occupancy bookkeeping; a flush empties the queue at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (enq) wrPtr <= wrPtr + 1'b1;
         if (deq) rdPtr <= rdPtr + 1'b1;
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage needs no reset; stale words are hidden by the count
   always_ff @(posedge clk) begin
      if (enq) mem[wrPtr] <= enqData;
   end

   assign head  = mem[rdPtr];
   assign empty = (count == '0);
   assign full  = (count == FULL_COUNT);

endmodule

// File: rtl/fetch_buf.sv
// Instruction fetch buffer: owns the fetch PC, queues fetched words for
// decode and restarts fetching on a redirect from execute.
// Define FETCH_BUF_BYPASS_EN to let an empty buffer pass the memory word
// straight to decode in the same cycle.
module fetch_buf
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = FETCH_DEPTH_DEF,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        deq_ready,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
);

   localparam int CW = $clog2(DEPTH+1);

   logic [31:0]    fetchPc;
   logic [CW-1:0]  count;
   logic           fifoEmpty;
   logic           fifoFull;
   fetch_entry_t   headEntry;
   fetch_entry_t   newEntry;
   logic           enq;
   logic           deq;
   logic           bypassTake;
   logic           pcAdvance;

   assign imem_addr = fetchPc;
   assign newEntry  = '{pc: fetchPc, instr: imem_instr};

   // Decide this cycle's queue movements; a redirect freezes both sides
   always_comb begin
      deq        = !redirect && !fifoEmpty && deq_ready;
`ifdef FETCH_BUF_BYPASS_EN
      bypassTake = !redirect && fifoEmpty && deq_ready;
`else
      bypassTake = 1'b0;
`endif
      enq        = !redirect && !bypassTake && (!fifoFull || deq);
      pcAdvance  = enq || bypassTake;
   end

   // Present the head entry to decode, or the live memory word when bypassing
   always_comb begin
      instr_valid = !fifoEmpty;
      instr       = fifoEmpty ? 32'h0 : headEntry.instr;
      instr_pc    = fifoEmpty ? 32'h0 : headEntry.pc;
`ifdef FETCH_BUF_BYPASS_EN
      if (rst && fifoEmpty && !redirect) begin
         instr_valid = 1'b1;
         instr       = imem_instr;
         instr_pc    = fetchPc;
      end
`endif
   end

   // Fetch address: redirect wins, otherwise step whenever a word is taken
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetchPc <= RESET_PC;
      end else if (redirect) begin
         fetchPc <= redirect_pc;
      end else if (pcAdvance) begin
         fetchPc <= nextPc(fetchPc);
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (redirect),
      .enq     (enq),
      .enqData (newEntry),
      .deq     (deq),
      .head    (headEntry),
      .count   (count),
      .empty   (fifoEmpty),
      .full    (fifoFull)
   );

endmodule

// File: doc/fetch_buf.md
FETCH_BUF -- requirements
Module: fetch_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered instructions; power of two, at least 2.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port imem_addr, output, 32, fetch address to instruction memory.
REQ-006 SHALL have port imem_instr, input, 32, instruction word from memory; combinational read of imem_addr.
REQ-007 SHALL have port redirect, input, 1, taken branch/PC write from execute; flush request.
REQ-008 SHALL have port redirect_pc, input, 32, new fetch address, valid when redirect=1.
REQ-009 SHALL have port deq_ready, input, 1, decode accepts the head entry this cycle (inverse of fetch stall).
REQ-010 SHALL have port instr_valid, output, 1, instr and instr_pc hold a valid entry.
REQ-011 SHALL have port instr, output, 32, head instruction word.
REQ-012 SHALL have port instr_pc, output, 32, address of the head instruction.

Function
REQ-013 SHALL hold a fetch_pc register; imem_addr SHALL equal fetch_pc combinationally.
REQ-014 Enqueue SHALL occur when count<DEPTH, or count==DEPTH with a dequeue in the same cycle; entry = {fetch_pc, imem_instr}; fetch_pc += 4 (mod 2^32).
REQ-015 Dequeue SHALL occur when instr_valid=1 and deq_ready=1; head pointer advances.
REQ-016 Simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-017 Read/write pointers SHALL wrap modulo DEPTH; count width SHALL be clog2(DEPTH+1).
REQ-018 Without bypass, latency imem_addr to instr_valid SHALL be exactly 1 cycle.
REQ-019 Redirect SHALL take priority: count, pointers cleared; fetch_pc loaded with redirect_pc; no enqueue/dequeue that cycle.
REQ-020 Cycle after redirect, imem_addr SHALL equal redirect_pc and instr_valid SHALL be 0 (non-bypass).
REQ-021 When full and deq_ready=0, fetch_pc and all entries SHALL hold.
REQ-022 When empty, instr/instr_pc SHALL be don't-care; instr_valid=0.

Reset
REQ-023 On rst=0 (asynchronous): fetch_pc=RESET_PC, count=0, pointers=0, instr_valid=0, instr=0, instr_pc=0.
REQ-024 Reset asserted mid-operation SHALL discard all entries; first fetch after release SHALL be RESET_PC.

Configuration
REQ-025 Macro FETCH_BUF_BYPASS_EN SHALL, when defined, enable a zero-latency bypass: when count==0 and redirect=0, instr_valid=1, instr=imem_instr, instr_pc=fetch_pc combinationally; with deq_ready=1 the word is consumed without being written and fetch_pc advances.
REQ-026 Without FETCH_BUF_BYPASS_EN, the bypass path SHALL be absent and REQ-018 latency SHALL apply.

Structure
REQ-027 Package fetch_pkg SHALL hold typedef fetch_entry_t {pc[31:0], instr[31:0]}, constant FETCH_DEPTH_DEF=4, constant PC_STEP=4.
REQ-028 Storage and pointers SHALL be a sub-module fetch_fifo (parameterised DEPTH, entry type fetch_entry_t); fetch_buf holds fetch_pc, redirect and bypass logic.

Verification
REQ-029 Reset release, deq_ready=1 always, imem returns addr^32'hA5A5_0000 -> instr_pc sequence 0,4,8,... from cycle 1, each instr matching.
REQ-030 deq_ready=0 for 6 cycles from reset -> count saturates at 4, imem_addr holds 32'h10, instr_pc stays 0.
REQ-031 Full buffer, then deq_ready=1 -> one entry per cycle, simultaneous enqueue, instr_pc 0,4,8,12,16 with no gap.
REQ-032 redirect=1, redirect_pc=32'h40 while 3 entries held -> next cycle instr_valid=0, imem_addr=32'h40; following cycle instr_pc=32'h40.
REQ-033 rst=0 asserted between clock edges with 2 entries -> instr_valid=0 immediately, fetch restarts at RESET_PC.
REQ-034 With FETCH_BUF_BYPASS_EN, empty buffer, deq_ready=1 -> instr_valid=1 in cycle 0 with instr_pc=RESET_PC; count remains 0.
